// File: rtl/uc_fp_mult.sv
// uc_fp_mult -- control unit for the single-precision FP multiplier datapath.
//
// Resets and times the iterative mantissa multiplier. From the raw product it
// selects the normalisation shift and the exponent correction, and it drives
// the rounding step. When rounding carries out of the mantissa, it runs one
// renormalisation pass. It raises pronto for one cycle when produto is valid.
//
// Build option: define FPMULT_ROUND_EN to enable round-to-nearest-even and the
// RENORM pass. When it is undefined, the datapath truncates, sinalRound stays 0,
// and RENORM is never entered.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   iniciar        start request (sampled only in IDLE)
//   exp_a, exp_b   biased operand exponents
//   ula[53:0]      raw mantissa product from the datapath
//   ula_reset      reset pulse to the mantissa multiplier (CLR)
//   sinalMuxFP1    exponent mux: 0 = exponent sum, 1 = registered exponent
//   sinalMuxFP2    fraction mux: 0 = ula[53:27], 1 = registered fraction
//   sinalRound     1 = round-to-nearest-even on capture
//   sinalShiftRes  {left/right, amount}
//   sinalIncOrDec  {subtract/add, amount}; the datapath adds a further +127
//   ocupado        busy from CLR through DONE
//   pronto         one-cycle result-valid pulse
//   overflow, underflow, zero   registered exception flags
module uc_fp_mult #(
   parameter int unsigned MULT_CYCLES = 28
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic [7:0]  exp_a,
   input  logic [7:0]  exp_b,
   input  logic [53:0] ula,
   output logic        ula_reset,
   output logic        sinalMuxFP1,
   output logic        sinalMuxFP2,
   output logic        sinalRound,
   output logic [8:0]  sinalShiftRes,
   output logic [8:0]  sinalIncOrDec,
   output logic        ocupado,
   output logic        pronto,
   output logic        overflow,
   output logic        underflow,
   output logic        zero
);

   localparam int unsigned CW = $clog2(MULT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(MULT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLR, MULT, NORM, RENORM, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [8:0]    shift_q;
   logic [8:0]    incdec_q;

   // ula[53] set means the product is in [2,4): shift by 1, otherwise by 2
   logic        s1;
   logic [22:0] mant;
   logic [2:0]  guard;
   logic        round_up;
   logic        norm_ovf;
   logic        ovf;
   logic        round_en;
   logic        unused_bits;
   logic [8:0]  norm_sel;

   assign s1 = ula[53];

   always_comb begin
      mant  = ula[51:29];
      guard = ula[28:26];
      if (s1) begin
         mant  = ula[52:30];
         guard = ula[29:27];
      end
   end

   // Round half to even. Carry-out happens only when the mantissa is all ones.
   assign round_up = (guard > 3'b100) || ((guard == 3'b100) && mant[0]);
   assign norm_ovf = (&mant) && round_up;

`ifdef FPMULT_ROUND_EN
   assign ovf         = norm_ovf;
   assign round_en    = 1'b1;
   assign unused_bits = ^ula[25:0];
`else
   assign ovf         = 1'b0;
   assign round_en    = 1'b0;
   assign unused_bits = ^{ula[25:0], norm_ovf};
`endif

   // Result exponent before the datapath bias: ea + eb - 127 + (s==1) + ovf
   logic signed [9:0] e_sum;
   logic              zero_n;
   logic              ovfl_n;
   logic              unfl_n;

   always_comb begin
      e_sum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127
             + $signed({9'b0, s1}) + $signed({9'b0, ovf});
      zero_n = (exp_a == 8'h00) || (exp_b == 8'h00);
      ovfl_n = !zero_n && (e_sum > 10'sd254);
      unfl_n = !zero_n && (e_sum < 10'sd1);
   end

   // NORM decodes ula live because the round register captures at the end of
   // that same cycle. In every other state the selects come from registers.
   assign norm_sel      = {1'b1, 6'b0, ~s1, s1};
   assign sinalShiftRes = (state == NORM) ? norm_sel : shift_q;
   assign sinalIncOrDec = (state == NORM) ? norm_sel : incdec_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         ula_reset   <= 1'b0;
         sinalMuxFP1 <= 1'b0;
         sinalMuxFP2 <= 1'b0;
         sinalRound  <= 1'b0;
         shift_q     <= '0;
         incdec_q    <= '0;
         ocupado     <= 1'b0;
         pronto      <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         zero        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (iniciar) begin
                  state     <= CLR;
                  ula_reset <= 1'b1;
                  ocupado   <= 1'b1;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  zero      <= 1'b0;
               end
            end
            CLR: begin
               state     <= MULT;
               ula_reset <= 1'b0;
               cnt       <= '0;
            end
            MULT: begin
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state      <= NORM;
                  sinalRound <= round_en;
               end
            end
            NORM: begin
               overflow   <= ovfl_n;
               underflow  <= unfl_n;
               zero       <= zero_n;
               sinalRound <= 1'b0;
               if (ovf) begin
                  // Recapture the registered result: exponent +1, mantissa 0
                  state       <= RENORM;
                  sinalMuxFP1 <= 1'b1;
                  sinalMuxFP2 <= 1'b1;
                  shift_q     <= 9'h101;
                  incdec_q    <= 9'h17E;
               end else begin
                  state  <= DONE;
                  pronto <= 1'b1;
               end
            end
`ifdef FPMULT_ROUND_EN
            RENORM: begin
               state       <= DONE;
               sinalMuxFP1 <= 1'b0;
               sinalMuxFP2 <= 1'b0;
               shift_q     <= '0;
               incdec_q    <= '0;
               pronto      <= 1'b1;
            end
`endif
            DONE: begin
               state   <= IDLE;
               pronto  <= 1'b0;
               ocupado <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uc_fp_mult.sv
module tb_uc_fp_mult;

   localparam int unsigned MC = 4;
`ifdef FPMULT_ROUND_EN
   localparam logic RND = 1'b1;
`else
   localparam logic RND = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        iniciar;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [53:0] ula;
   logic        ula_reset;
   logic        sinalMuxFP1;
   logic        sinalMuxFP2;
   logic        sinalRound;
   logic [8:0]  sinalShiftRes;
   logic [8:0]  sinalIncOrDec;
   logic        ocupado;
   logic        pronto;
   logic        overflow;
   logic        underflow;
   logic        zero;

   int checks = 0;
   int errors = 0;

   uc_fp_mult #(.MULT_CYCLES(MC)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .exp_a        (exp_a),
      .exp_b        (exp_b),
      .ula          (ula),
      .ula_reset    (ula_reset),
      .sinalMuxFP1  (sinalMuxFP1),
      .sinalMuxFP2  (sinalMuxFP2),
      .sinalRound   (sinalRound),
      .sinalShiftRes(sinalShiftRes),
      .sinalIncOrDec(sinalIncOrDec),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .overflow     (overflow),
      .underflow    (underflow),
      .zero         (zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {ula_reset, mux1, mux2, round, ocupado, pronto}
   logic [5:0] ctl;
   logic [2:0] flags;
   assign ctl   = {ula_reset, sinalMuxFP1, sinalMuxFP2, sinalRound, ocupado, pronto};
   assign flags = {overflow, underflow, zero};

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One operation: checks every cycle from CLR to the following IDLE.
   // ovf_vec: the vector carries out of the mantissa when rounding is on.
   task automatic run_op(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [53:0] u, input logic ovf_vec, input logic [2:0] fl);
      logic [8:0] sh;
      logic       rn;
      sh = u[53] ? 9'h101 : 9'h102;
      rn = RND & ovf_vec;
      exp_a   = ea;
      exp_b   = eb;
      ula     = u;
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      chk({tag, "/clr_ctl"}, ctl, 9'b000_100010);
      chk({tag, "/clr_flags"}, flags, 9'h000);
      for (int c = 0; c < MC; c++) begin
         step();
         chk({tag, "/mult_ctl"}, ctl, 9'b000_000010);
         chk({tag, "/mult_shift"}, sinalShiftRes, 9'h000);
      end
      step();
      chk({tag, "/norm_ctl"}, ctl, {5'b00000, RND, 3'b010});
      chk({tag, "/norm_shift"}, sinalShiftRes, sh);
      chk({tag, "/norm_incdec"}, sinalIncOrDec, sh);
      chk({tag, "/norm_flags"}, flags, 9'h000);
      if (rn) begin
         step();
         chk({tag, "/renorm_ctl"}, ctl, 9'b000_011010);
         chk({tag, "/renorm_shift"}, sinalShiftRes, 9'h101);
         chk({tag, "/renorm_incdec"}, sinalIncOrDec, 9'h17E);
         chk({tag, "/renorm_flags"}, flags, {6'b0, fl});
      end
      step();
      chk({tag, "/done_ctl"}, ctl, 9'b000_000011);
      chk({tag, "/done_shift"}, sinalShiftRes, 9'h000);
      chk({tag, "/done_incdec"}, sinalIncOrDec, 9'h000);
      chk({tag, "/done_flags"}, flags, {6'b0, fl});
      step();
      chk({tag, "/idle_ctl"}, ctl, 9'h000);
      chk({tag, "/idle_flags"}, flags, {6'b0, fl});
   endtask

   localparam logic [53:0] U15  = {1'b1, 53'b0};
   localparam logic [53:0] U10  = {2'b01, 52'b0};
   localparam logic [53:0] UOV2 = {2'b01, 23'h7FFFFF, 3'b100, 26'b0};
   localparam logic [53:0] UOV1 = {1'b1, 23'h7FFFFF, 3'b101, 27'b0};
   localparam logic [53:0] UNR1 = {2'b01, 23'h7FFFFF, 3'b011, 26'b0};
   localparam logic [53:0] UNR2 = {2'b01, 23'h7FFFFE, 3'b111, 26'b0};

   int pcount;

   initial begin
      reset   = 1'b1;
      iniciar = 1'b0;
      exp_a   = '0;
      exp_b   = '0;
      ula     = '0;
      step();
      step();
      chk("reset_ctl", ctl, 9'h000);
      chk("reset_shift", sinalShiftRes, 9'h000);
      chk("reset_incdec", sinalIncOrDec, 9'h000);
      chk("reset_flags", flags, 9'h000);
      reset = 1'b0;
      step();

      run_op("mul15",  8'h7F, 8'h7F, U15,  1'b0, 3'b000);
      run_op("mul10",  8'h7F, 8'h7F, U10,  1'b0, 3'b000);
      run_op("rndovf", 8'h7F, 8'h7F, UOV2, 1'b1, 3'b000);
      run_op("rndov1", 8'h7F, 8'h7F, UOV1, 1'b1, 3'b000);
      run_op("nornd1", 8'h7F, 8'h7F, UNR1, 1'b0, 3'b000);
      run_op("nornd2", 8'h7F, 8'h7F, UNR2, 1'b0, 3'b000);
      run_op("ovfl",   8'hFE, 8'hFE, U15,  1'b0, 3'b100);
      run_op("unfl",   8'h01, 8'h01, U10,  1'b0, 3'b010);
      run_op("zero",   8'h00, 8'h01, U10,  1'b0, 3'b001);
      run_op("zero2",  8'h7F, 8'h00, U15,  1'b0, 3'b001);
      run_op("e254",   8'hFE, 8'h7E, U15,  1'b0, 3'b000);
      run_op("e255",   8'hFE, 8'h7F, U15,  1'b0, 3'b100);
      run_op("e1",     8'h01, 8'h7F, U10,  1'b0, 3'b000);
      run_op("e0",     8'h01, 8'h7E, U10,  1'b0, 3'b010);
      run_op("rndhi",  8'hFE, 8'h7F, UOV2, 1'b1, {RND, 2'b00});

      // Reset during the second MULT cycle abandons the operation
      exp_a   = 8'h7F;
      exp_b   = 8'h7F;
      ula     = U15;
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_ctl", ctl, 9'h000);
      chk("abort_shift", sinalShiftRes, 9'h000);
      chk("abort_incdec", sinalIncOrDec, 9'h000);
      pcount = 0;
      for (int c = 0; c < MC + 6; c++) begin
         step();
         if (pronto) pcount++;
      end
      chk("abort_pronto", 9'(pcount), 9'd0);
      chk("abort_idle", ctl, 9'h000);

      // iniciar held high through the operation: exactly one result
      pcount  = 0;
      iniciar = 1'b1;
      for (int c = 0; c < 2 * (MC + 5); c++) begin
         step();
         if (pronto) begin
            pcount++;
            iniciar = 1'b0;
         end
      end
      iniciar = 1'b0;
      chk("hold_pronto", 9'(pcount), 9'd1);
      chk("hold_idle", ctl, 9'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
